branch_pred_unit: RTL

//  Parametrised direct-mapped BTB with per-entry saturating direction counters for the fetch stage.
//  - F side: looks up the fetch PC combinationally and supplies the predicted next PC.
//  - E side: resolved branches/jumps update the table; mispredicts are flagged and redirected.
//  - Keeps saturating statistics counters.

---
 rtl/branch_pred_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/branch_pred_unit.sv
// branch_pred_unit: direct-mapped branch target buffer with per-entry
// saturating direction counters. The fetch side gets a 0-cycle combinational
// prediction. The execute side trains the table, flags mispredictions and
// supplies the corrected next PC. Two saturating counters keep statistics.
module branch_pred_unit #(
    parameter int ADDR     = 32,
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    // fetch-side lookup
    input  logic [ADDR-1:0]   f_pc,
    output logic              f_hit,
    output logic              f_taken,
    output logic [ADDR-1:0]   f_next_pc,
    // execute-side resolution
    input  logic              e_valid,
    input  logic [ADDR-1:0]   e_pc,
    input  logic              e_jump,
    input  logic              e_taken,
    input  logic [ADDR-1:0]   e_target,
    input  logic              e_pred_taken,
    input  logic [ADDR-1:0]   e_pred_target,
    output logic              e_mispredict,
    output logic [ADDR-1:0]   e_redirect_pc,
    // maintenance and statistics
    input  logic              flush_all,
    output logic [STAT_W-1:0] stat_ctrl,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR - IDX - 2;

    localparam logic [CTR_BITS-1:0] CTR_ONE  = 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    // Weakly taken has only the MSB set; weakly not-taken sits one below it.
    localparam logic [CTR_BITS-1:0] CTR_WT   = CTR_ONE << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_WT - CTR_ONE;
    localparam logic [STAT_W-1:0]   STAT_ONE = 1;
    localparam logic [STAT_W-1:0]   STAT_MAX = '1;

    // Table storage. Kept in registers because the lookup must be
    // combinational and a reset must clear every entry at once.
    logic                r_valid  [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [ADDR-1:0]     r_target [ENTRIES];
    logic                r_jump   [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

    logic [STAT_W-1:0]   r_stat_ctrl;
    logic [STAT_W-1:0]   r_stat_miss;

    logic [IDX-1:0]      w_f_idx;
    logic [TAG_W-1:0]    w_f_tag;
    logic [IDX-1:0]      w_e_idx;
    logic [TAG_W-1:0]    w_e_tag;
    logic                w_e_hit;
    logic                w_act_taken;

    logic                w_wr_en;
    logic [ADDR-1:0]     w_wr_target;
    logic                w_wr_jump;
    logic [CTR_BITS-1:0] w_wr_ctr;

    assign w_f_idx = f_pc[IDX+1:2];
    assign w_f_tag = f_pc[ADDR-1:IDX+2];
    assign w_e_idx = e_pc[IDX+1:2];
    assign w_e_tag = e_pc[ADDR-1:IDX+2];

    // Fetch lookup reads the current contents. A same-cycle write
    // therefore becomes visible only from the next cycle on.
    assign f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign f_taken   = f_hit && (r_jump[w_f_idx] || r_ctr[w_f_idx][CTR_BITS-1]);
    assign f_next_pc = f_taken ? r_target[w_f_idx] : f_pc + ADDR'(4);

    // Resolution: a jump is always taken, whatever e_taken says.
    assign w_act_taken   = e_jump | e_taken;
    assign w_e_hit       = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
    assign e_mispredict  = e_valid && ((w_act_taken != e_pred_taken) ||
                                       (w_act_taken && (e_target != e_pred_target)));
    assign e_redirect_pc = w_act_taken ? e_target : e_pc + ADDR'(4);

    assign stat_ctrl = r_stat_ctrl;
    assign stat_miss = r_stat_miss;

    // Work out the new contents of the entry selected by e_pc.
    // Fields that are not rewritten keep their old value.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_target = r_target[w_e_idx];
        w_wr_jump   = r_jump[w_e_idx];
        w_wr_ctr    = r_ctr[w_e_idx];
        if (e_valid) begin
            if (w_e_hit) begin
                w_wr_en = 1'b1;
                if (e_jump) begin
                    w_wr_target = e_target;
                    w_wr_jump   = 1'b1;
                end else if (r_jump[w_e_idx]) begin
                    // Entry learned as a jump now behaves as a branch:
                    // restart the counter at the weak state of this outcome.
                    w_wr_jump = 1'b0;
                    w_wr_ctr  = e_taken ? CTR_WT : CTR_WNT;
                    if (e_taken) begin
                        w_wr_target = e_target;
                    end
                end else if (e_taken) begin
                    w_wr_target = e_target;
                    if (r_ctr[w_e_idx] != CTR_MAX) begin
                        w_wr_ctr = r_ctr[w_e_idx] + CTR_ONE;
                    end
                end else if (r_ctr[w_e_idx] != '0) begin
                    w_wr_ctr = r_ctr[w_e_idx] - CTR_ONE;
                end
            end else if (w_act_taken) begin
                // Allocate or replace only on taken control flow.
                // A not-taken branch that misses leaves the table alone.
                w_wr_en     = 1'b1;
                w_wr_target = e_target;
                w_wr_jump   = e_jump;
                if (!e_jump) begin
                    w_wr_ctr = CTR_WT;
                end
            end
        end
    end

    // Table update: reset beats flush, and flush beats a training write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= '0;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_wr_en) begin
            r_valid[w_e_idx]  <= 1'b1;
            r_tag[w_e_idx]    <= w_e_tag;
            r_target[w_e_idx] <= w_wr_target;
            r_jump[w_e_idx]   <= w_wr_jump;
            r_ctr[w_e_idx]    <= w_wr_ctr;
        end
    end

    // Saturating statistics. Flush does not touch them; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stat_ctrl <= '0;
            r_stat_miss <= '0;
        end else begin
            if (e_valid && (r_stat_ctrl != STAT_MAX)) begin
                r_stat_ctrl <= r_stat_ctrl + STAT_ONE;
            end
            if (e_mispredict && (r_stat_miss != STAT_MAX)) begin
                r_stat_miss <= r_stat_miss + STAT_ONE;
            end
        end
    end

endmodule
